// File: rtl/pc_sequencer_if.sv
// Fetch-side bundle between pc_sequencer (master) and instruction memory / datapath (slave).
// Carries per-cycle control into the sequencer and the registered PC and status back out.
interface pc_sequencer_if #(
  parameter int PC_W    = 8,
  parameter int INSTR_W = 9,
  parameter int CNT_W   = 16
);
  logic [INSTR_W-1:0] instr;
  logic               stall;
  logic               branch;
  logic [PC_W-1:0]    branch_off;
  logic [PC_W-1:0]    pc;
  logic               fetch_valid;
  logic               done;
  logic               fault;
  logic [CNT_W-1:0]   cycle_count;
  logic [CNT_W-1:0]   instr_count;

  modport master (
    input  instr, stall, branch, branch_off,
    output pc, fetch_valid, done, fault, cycle_count, instr_count
  );

  modport slave (
    output instr, stall, branch, branch_off,
    input  pc, fetch_valid, done, fault, cycle_count, instr_count
  );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter / fetch sequencer: PC, relative branches, halt and range-fault detection, saturating counters.
// PC updates one cycle after its inputs; stall holds the PC for as long as it is asserted.
module pc_sequencer #(
  parameter int                 PC_W       = 8,
  parameter int                 INSTR_W    = 9,
  parameter logic [INSTR_W-1:0] HALT_INSTR = 9'b101100100,
  parameter int                 CNT_W      = 16,
  parameter int                 WRAP_EN    = 0
) (
  input  logic           clk,
  input  logic           start,
  pc_sequencer_if.master bus
);

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_HALTED = 2'd1,
    S_FAULT  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           r_state;
  logic [PC_W-1:0]  r_pc;
  logic [CNT_W-1:0] r_cycle;
  logic [CNT_W-1:0] r_instr;

  logic [PC_W:0]    w_step;
  logic [PC_W:0]    w_target;
  logic             w_out_of_range;
  logic             w_is_halt;
  logic [CNT_W-1:0] w_cycle_next;
  logic [CNT_W-1:0] w_instr_next;

  // One extra bit catches both negative targets and overflow past the top of memory.
  assign w_step         = bus.branch ? {bus.branch_off[PC_W-1], bus.branch_off} : (PC_W+1)'(1);
  assign w_target       = {1'b0, r_pc} + w_step;
  assign w_out_of_range = w_target[PC_W];
  assign w_is_halt      = (bus.instr == HALT_INSTR);

  assign w_cycle_next = (r_cycle == CNT_MAX) ? r_cycle : r_cycle + CNT_W'(1);
  assign w_instr_next = (r_instr == CNT_MAX) ? r_instr : r_instr + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (start) begin
      r_state <= S_RUN;
      r_pc    <= '0;
      r_cycle <= '0;
      r_instr <= '0;
    end else begin
      case (r_state)
        S_RUN: begin
          r_cycle <= w_cycle_next;
          if (!bus.stall) begin
            if (w_is_halt) begin
              r_state <= S_HALTED;
            end else if (!w_out_of_range || (WRAP_EN != 0)) begin
              r_pc    <= w_target[PC_W-1:0];
              r_instr <= w_instr_next;
            end else begin
              r_state <= S_FAULT;
            end
          end
        end
        default: begin
          // HALTED and FAULT hold everything until the next start.
          r_state <= r_state;
        end
      endcase
    end
  end

  assign bus.pc          = r_pc;
  assign bus.cycle_count = r_cycle;
  assign bus.instr_count = r_instr;
  assign bus.fetch_valid = (r_state == S_RUN);
  assign bus.done        = (r_state == S_HALTED) || (r_state == S_FAULT);
  assign bus.fault       = (r_state == S_FAULT);

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: one non-wrapping instance (16-bit counters) and one wrapping instance (5-bit counters).
// Directed scenarios use hand-derived constants; the random run compares against an integer reference model.
module tb_pc_sequencer;
  localparam logic [8:0] HALT = 9'b101100100;

  logic       clk = 1'b0;
  logic       start;
  logic       stall;
  logic       branch;
  logic [7:0] branch_off;
  logic [8:0] prog [256];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pc_sequencer_if #(.PC_W(8), .INSTR_W(9), .CNT_W(16)) bus0 ();
  pc_sequencer_if #(.PC_W(8), .INSTR_W(9), .CNT_W(5))  bus1 ();

  assign bus0.stall      = stall;
  assign bus0.branch     = branch;
  assign bus0.branch_off = branch_off;
  assign bus0.instr      = prog[bus0.pc];
  assign bus1.stall      = stall;
  assign bus1.branch     = branch;
  assign bus1.branch_off = branch_off;
  assign bus1.instr      = prog[bus1.pc];

  pc_sequencer #(.PC_W(8), .INSTR_W(9), .HALT_INSTR(HALT), .CNT_W(16), .WRAP_EN(0)) dut0 (
    .clk(clk), .start(start), .bus(bus0.master));
  pc_sequencer #(.PC_W(8), .INSTR_W(9), .HALT_INSTR(HALT), .CNT_W(5), .WRAP_EN(1)) dut1 (
    .clk(clk), .start(start), .bus(bus1.master));

  // Reference model: state 0=run, 1=halted, 2=fault; plain integer PC arithmetic.
  int m_pc[2], m_st[2], m_cc[2], m_ic[2];
  int cnt_max[2] = '{65535, 31};
  int wrap[2]    = '{0, 1};

  always @(posedge clk) begin
    int tgt, off;
    for (int k = 0; k < 2; k++) begin
      if (start === 1'b1) begin
        m_pc[k] = 0; m_st[k] = 0; m_cc[k] = 0; m_ic[k] = 0;
      end else if (m_st[k] == 0) begin
        if (m_cc[k] < cnt_max[k]) m_cc[k]++;
        if (stall !== 1'b1) begin
          if (prog[m_pc[k]] == HALT) begin
            m_st[k] = 1;
          end else begin
            off = int'(branch_off);
            if (off > 127) off -= 256;
            tgt = branch ? m_pc[k] + off : m_pc[k] + 1;
            if ((tgt >= 0 && tgt <= 255) || wrap[k] == 1) begin
              m_pc[k] = (tgt + 256) % 256;
              if (m_ic[k] < cnt_max[k]) m_ic[k]++;
            end else begin
              m_st[k] = 2;
            end
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    start = 1'b1; stall = 1'b0; branch = 1'b0; branch_off = 8'h00;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    start = 1'b1; stall = 1'b0; branch = 1'b0; branch_off = 8'h00;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (bus0.pc !== 8'd0 || bus0.done !== 1'b0 || bus0.fault !== 1'b0 ||
          bus0.cycle_count !== 16'd0 || bus0.instr_count !== 16'd0 || bus0.fetch_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL reset_hold got pc=%0d done=%b fault=%b cc=%0d ic=%0d fv=%b want 0 0 0 0 0 1",
                 bus0.pc, bus0.done, bus0.fault, bus0.cycle_count, bus0.instr_count, bus0.fetch_valid);
      end
    end
    start = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      n_checks++;
      if (bus0.pc !== 8'(i) || bus1.pc !== 8'(i) || bus0.fetch_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL reset_count got pc0=%0d pc1=%0d fv=%b want pc=%0d fv=1", bus0.pc, bus1.pc, bus0.fetch_valid, i);
      end
    end
  endtask

  task automatic test_halt();
    prog[5] = HALT;
    do_reset();
    repeat (5) tick();
    n_checks++;
    if (bus0.pc !== 8'd5 || bus0.done !== 1'b0) begin
      n_fail++;
      $display("FAIL halt_reach got pc=%0d done=%b want pc=5 done=0", bus0.pc, bus0.done);
    end
    tick();
    n_checks++;
    if (bus0.done !== 1'b1 || bus0.pc !== 8'd5 || bus0.instr_count !== 16'd5 ||
        bus0.cycle_count !== 16'd6 || bus0.fetch_valid !== 1'b0 || bus0.fault !== 1'b0) begin
      n_fail++;
      $display("FAIL halt_state got done=%b pc=%0d ic=%0d cc=%0d fv=%b fault=%b want 1 5 5 6 0 0",
               bus0.done, bus0.pc, bus0.instr_count, bus0.cycle_count, bus0.fetch_valid, bus0.fault);
    end
    for (int i = 0; i < 3; i++) begin
      stall = 1'($urandom_range(0, 1)); branch = 1'($urandom_range(0, 1)); branch_off = 8'($urandom);
      tick();
      n_checks++;
      if (bus0.pc !== 8'd5 || bus0.instr_count !== 16'd5 || bus0.cycle_count !== 16'd6 ||
          bus1.pc !== 8'd5 || bus1.done !== 1'b1) begin
        n_fail++;
        $display("FAIL halt_frozen got pc0=%0d ic=%0d cc=%0d pc1=%0d done1=%b want 5 5 6 5 1",
                 bus0.pc, bus0.instr_count, bus0.cycle_count, bus1.pc, bus1.done);
      end
    end
    prog[5] = 9'd0;
  endtask

  task automatic test_branch();
    do_reset();
    repeat (10) tick();
    n_checks++;
    if (bus0.pc !== 8'd10) begin
      n_fail++;
      $display("FAIL branch_setup got pc=%0d want 10", bus0.pc);
    end
    branch = 1'b1; branch_off = 8'hFC;
    tick();
    n_checks++;
    if (bus0.pc !== 8'd6 || bus1.pc !== 8'd6) begin
      n_fail++;
      $display("FAIL branch_back got pc0=%0d pc1=%0d want 6", bus0.pc, bus1.pc);
    end
    branch_off = 8'h07;
    tick();
    n_checks++;
    if (bus0.pc !== 8'd13 || bus0.instr_count !== 16'd12 || bus0.fault !== 1'b0) begin
      n_fail++;
      $display("FAIL branch_fwd got pc=%0d ic=%0d fault=%b want 13 12 0", bus0.pc, bus0.instr_count, bus0.fault);
    end
    branch = 1'b0;
  endtask

  task automatic test_stall();
    prog[3] = HALT;
    do_reset();
    repeat (3) tick();
    stall = 1'b1; branch = 1'b1; branch_off = 8'h05;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if (bus0.pc !== 8'd3 || bus0.fetch_valid !== 1'b1 || bus0.done !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_hold got pc=%0d fv=%b done=%b want 3 1 0", bus0.pc, bus0.fetch_valid, bus0.done);
      end
    end
    n_checks++;
    if (bus0.cycle_count !== 16'd7 || bus0.instr_count !== 16'd3) begin
      n_fail++;
      $display("FAIL stall_counts got cc=%0d ic=%0d want 7 3", bus0.cycle_count, bus0.instr_count);
    end
    stall = 1'b0; branch = 1'b0;
    tick();
    n_checks++;
    if (bus0.done !== 1'b1 || bus0.cycle_count !== 16'd8 || bus0.pc !== 8'd3) begin
      n_fail++;
      $display("FAIL stall_release got done=%b cc=%0d pc=%0d want 1 8 3", bus0.done, bus0.cycle_count, bus0.pc);
    end
    prog[3] = 9'd0;
  endtask

  task automatic test_fault_wrap();
    do_reset();
    branch = 1'b1; branch_off = 8'd127;
    tick(); tick();
    branch = 1'b0;
    tick();
    n_checks++;
    if (bus0.pc !== 8'd255 || bus1.pc !== 8'd255) begin
      n_fail++;
      $display("FAIL top_setup got pc0=%0d pc1=%0d want 255", bus0.pc, bus1.pc);
    end
    tick();
    n_checks++;
    if (bus0.fault !== 1'b1 || bus0.done !== 1'b1 || bus0.pc !== 8'd255 ||
        bus0.instr_count !== 16'd3 || bus0.cycle_count !== 16'd4 || bus0.fetch_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL top_fault got fault=%b done=%b pc=%0d ic=%0d cc=%0d fv=%b want 1 1 255 3 4 0",
               bus0.fault, bus0.done, bus0.pc, bus0.instr_count, bus0.cycle_count, bus0.fetch_valid);
    end
    n_checks++;
    if (bus1.pc !== 8'd0 || bus1.instr_count !== 5'd4 || bus1.fault !== 1'b0) begin
      n_fail++;
      $display("FAIL top_wrap got pc=%0d ic=%0d fault=%b want 0 4 0", bus1.pc, bus1.instr_count, bus1.fault);
    end
    do_reset();
    tick(); tick();
    branch = 1'b1; branch_off = 8'hFD;
    tick();
    n_checks++;
    if (bus0.fault !== 1'b1 || bus0.pc !== 8'd2 || bus1.pc !== 8'd255 || bus1.instr_count !== 5'd3) begin
      n_fail++;
      $display("FAIL neg_target got fault0=%b pc0=%0d pc1=%0d ic1=%0d want 1 2 255 3",
               bus0.fault, bus0.pc, bus1.pc, bus1.instr_count);
    end
    branch = 1'b0;
  endtask

  task automatic test_restart();
    start = 1'b1;
    tick();
    n_checks++;
    if (bus0.pc !== 8'd0 || bus0.fault !== 1'b0 || bus0.done !== 1'b0 || bus0.fetch_valid !== 1'b1 ||
        bus0.cycle_count !== 16'd0 || bus0.instr_count !== 16'd0) begin
      n_fail++;
      $display("FAIL restart_fault got pc=%0d fault=%b done=%b fv=%b cc=%0d ic=%0d want 0 0 0 1 0 0",
               bus0.pc, bus0.fault, bus0.done, bus0.fetch_valid, bus0.cycle_count, bus0.instr_count);
    end
    prog[2] = HALT;
    start = 1'b0;
    repeat (3) tick();
    n_checks++;
    if (bus0.done !== 1'b1 || bus0.fault !== 1'b0) begin
      n_fail++;
      $display("FAIL restart_halt_setup got done=%b fault=%b want 1 0", bus0.done, bus0.fault);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    n_checks++;
    if (bus0.pc !== 8'd0 || bus0.done !== 1'b0 || bus1.done !== 1'b0 || bus0.cycle_count !== 16'd0) begin
      n_fail++;
      $display("FAIL restart_halted got pc=%0d done0=%b done1=%b cc=%0d want 0 0 0 0",
               bus0.pc, bus0.done, bus1.done, bus0.cycle_count);
    end
    tick();
    n_checks++;
    if (bus0.pc !== 8'd1 || bus0.instr_count !== 16'd1) begin
      n_fail++;
      $display("FAIL restart_run got pc=%0d ic=%0d want 1 1", bus0.pc, bus0.instr_count);
    end
    prog[2] = 9'd0;
  endtask

  task automatic test_saturation();
    do_reset();
    branch = 1'b1; branch_off = 8'h00;
    repeat (40) tick();
    n_checks++;
    if (bus0.pc !== 8'd0 || bus0.instr_count !== 16'd40 || bus0.cycle_count !== 16'd40) begin
      n_fail++;
      $display("FAIL selfloop got pc=%0d ic=%0d cc=%0d want 0 40 40", bus0.pc, bus0.instr_count, bus0.cycle_count);
    end
    n_checks++;
    if (bus1.instr_count !== 5'd31 || bus1.cycle_count !== 5'd31 || bus1.fetch_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL saturate got ic=%0d cc=%0d fv=%b want 31 31 1", bus1.instr_count, bus1.cycle_count, bus1.fetch_valid);
    end
    branch = 1'b0;
  endtask

  task automatic test_random();
    int g_pc, g_cc, g_ic, g_fv, g_dn, g_ft;
    for (int a = 0; a < 256; a++)
      prog[a] = ($urandom_range(0, 99) < 3) ? HALT : 9'($urandom_range(0, 255));
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      start      = ($urandom_range(0, 99) < 2);
      stall      = ($urandom_range(0, 99) < 25);
      branch     = ($urandom_range(0, 99) < 35);
      branch_off = ($urandom_range(0, 1) == 1) ? 8'($urandom) : 8'($urandom_range(0, 4) - 2);
      tick();
      for (int k = 0; k < 2; k++) begin
        g_pc = (k == 0) ? int'(bus0.pc)          : int'(bus1.pc);
        g_cc = (k == 0) ? int'(bus0.cycle_count) : int'(bus1.cycle_count);
        g_ic = (k == 0) ? int'(bus0.instr_count) : int'(bus1.instr_count);
        g_fv = (k == 0) ? int'(bus0.fetch_valid) : int'(bus1.fetch_valid);
        g_dn = (k == 0) ? int'(bus0.done)        : int'(bus1.done);
        g_ft = (k == 0) ? int'(bus0.fault)       : int'(bus1.fault);
        n_checks++;
        if (g_pc !== m_pc[k] || g_cc !== m_cc[k] || g_ic !== m_ic[k] || g_fv !== int'(m_st[k] == 0) ||
            g_dn !== int'(m_st[k] != 0) || g_ft !== int'(m_st[k] == 2)) begin
          n_fail++;
          $display("FAIL random dut%0d cyc %0d got pc=%0d cc=%0d ic=%0d fv=%0d done=%0d fault=%0d want %0d %0d %0d st=%0d",
                   k, c, g_pc, g_cc, g_ic, g_fv, g_dn, g_ft, m_pc[k], m_cc[k], m_ic[k], m_st[k]);
        end
      end
    end
    start = 1'b0; stall = 1'b0; branch = 1'b0;
  endtask

  initial begin
    start = 1'b1; stall = 1'b0; branch = 1'b0; branch_off = 8'h00;
    for (int a = 0; a < 256; a++) prog[a] = 9'd0;
    @(negedge clk);
    test_reset();
    test_halt();
    test_branch();
    test_stall();
    test_fault_wrap();
    test_restart();
    test_saturation();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
